pwm_measure: RTL
================

// Module: pwm_measure
// PURPOSE
//  Downstream monitor for the PWM generator: samples a PWM waveform, measures period and
//  high time (in i_clk cycles) of every complete period, and counts completed periods.
//  Sits on the generator's output net (or an external pin); drives status/debug registers
//  and closed-loop checks. Detects a stalled waveform (no edges) via a programmable timeout.
// PARAMETERS
//  CNT_W    32          width of period/high counters and results
//  TIMES_W  16          width of completed-period counter
//  TIMEOUT  50_000_000  idle clocks (no rising edge) before a measurement aborts (1 s @50MHz)
// PORTS
//  i_clk      in   1        system clock, 50 MHz
//  i_rst      in   1        synchronous, active-high reset
//  i_clr      in   1        1-cycle pulse: abort measurement, clear results and counter
//  i_pwm      in   1        PWM input, asynchronous to i_clk allowed
//  o_period   out  CNT_W    last measured period, clocks rise-to-rise
//  o_high     out  CNT_W    last measured high time, clocks rise-to-fall
//  o_pulses   out  TIMES_W  completed periods since reset/clear, saturating
//  o_valid    out  1        1-cycle pulse: o_period/o_high updated this cycle
//  o_busy     out  1        1 while in MEAS state
//  o_timeout  out  1        1-cycle pulse: measurement aborted on timeout
// BEHAVIOUR
//  - Clock i_clk; reset synchronous, active-high (i_rst). All outputs reset to 0, FSM to IDLE.
//  - Input path: 2-flop synchroniser + 1 edge register; rise/fall flags assert 3 cycles after
//    the i_pwm transition. Rise and fall flags are mutually exclusive by construction.
//  - FSM: IDLE -> MEAS on first rise flag (arms only, no o_valid). MEAS -> MEAS on rise flag
//    (complete period). MEAS -> IDLE on timeout or i_clr. IDLE stays IDLE on fall flags.
//  - Period counter p_cnt: loaded with 1 on rise flag; else +1 per cycle in MEAS, saturating at
//    all-ones. Rises at cycles t and t+N give p_cnt == N at cycle t+N.
//  - On first fall flag after a rise: h_lat <= p_cnt; later falls in same period ignored.
//  - On rise flag in MEAS: o_period <= p_cnt, o_high <= h_lat, o_valid = 1 next cycle,
//    o_pulses += 1 (saturating at 2^TIMES_W-1), h_lat cleared.
//  - Latency: o_valid asserts 4 cycles after the i_pwm rising transition ending the period.
//  - Timeout: in MEAS, when p_cnt reaches TIMEOUT without a rise flag -> o_timeout pulse,
//    state IDLE; o_period/o_high/o_pulses keep last values. 0%/100% duty ends in timeout.
//  - i_clr: highest priority after i_rst; same cycle edge flags ignored; state IDLE,
//    o_period/o_high/o_pulses/h_lat cleared, no o_valid/o_timeout. Re-arms on next rise.
//  - Reset mid-period: partial period discarded; first rise after reset only arms.
//  - Counter saturation: o_period/o_high report all-ones when the true value exceeds width.
//  - o_busy = (state == MEAS), registered.
// STRUCTURE
//  - Shared header pwm_defs.vh: CNT_W/TIMES_W defaults and 50 MHz clock constant, shared
//    with the PWM generator; FSM state localparams (IDLE, MEAS) stay local.
//  - One sub-module: pwm_edge_sync (2-flop sync + edge register, outputs rise/fall flags).
//  - Top holds FSM, p_cnt, h_lat, result registers, pulse counter.
// TESTING
//  1) i_pwm period 10, high 4, 5 rising edges -> 4 o_valid pulses, o_period=10, o_high=4,
//     o_pulses=4, first o_valid 4 cycles after 2nd i_pwm rise.
//  2) TIMEOUT=100; period 10 waveform then i_pwm held 0 -> o_timeout 1 cycle, o_busy 0,
//     o_period=10 retained, no further o_valid.
//  3) i_clr asserted mid-period of period-20 waveform -> outputs 0, o_busy 0 next cycle;
//     next rise only arms; second rise -> o_valid with o_period=20, o_pulses=1.
//  4) i_rst asserted 5 cycles into a period -> all outputs 0; measurement restarts clean.
//  5) CNT_W=4, period 20 high 18 -> o_period=15, o_high=15 (saturated), o_valid still pulses.
//  6) Period changes 10 -> 7 (high 3) mid-stream -> one o_valid with 10, next with 7/3.

Source files
------------

// File: rtl/pwm_measure_pkg.sv
// Shared constants and types for the PWM measurement block and its generator peer.
// Latency: n/a.  Backpressure: n/a.
package pwm_measure_pkg;

    localparam int          CNT_W_DEF   = 32;
    localparam int          TIMES_W_DEF = 16;
    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned TIMEOUT_DEF = CLK_HZ;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } meas_state_t;

endpackage

// File: rtl/pwm_measure_edge_sync.sv
// Synchronises the PWM input and emits registered one-cycle rise/fall flags.
// Latency: flags assert 3 cycles after the input transition.  Backpressure: none.
module pwm_measure_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwm,
    output logic o_rise,
    output logic o_fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;
    logic fall_q,  fall_d;

    always_comb begin
        sync1_d = i_pwm;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        // Only one of these can be set for a given prev/current pair.
        rise_d  = sync2_q & ~prev_q;
        fall_d  = ~sync2_q & prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule

// File: rtl/pwm_measure.sv
// Measures period and high time of each complete PWM period; counts periods; flags stalls.
// Latency: o_valid 4 cycles after the closing rising edge.  Backpressure: none.
module pwm_measure
    import pwm_measure_pkg::*;
#(
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int          TIMES_W = TIMES_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_pwm,
    output logic [CNT_W-1:0]   o_period,
    output logic [CNT_W-1:0]   o_high,
    output logic [TIMES_W-1:0] o_pulses,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [TIMES_W-1:0] PULSE_MAX = '1;
    localparam logic [63:0]        TIMEOUT_X = 64'(TIMEOUT);

    logic rise, fall;

    pwm_measure_edge_sync u_edge_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pwm  (i_pwm),
        .o_rise (rise),
        .o_fall (fall)
    );

    meas_state_t        state_q,   state_d;
    logic [CNT_W-1:0]   p_cnt_q,   p_cnt_d;
    logic [CNT_W-1:0]   h_lat_q,   h_lat_d;
    logic               h_seen_q,  h_seen_d;
    logic [CNT_W-1:0]   period_q,  period_d;
    logic [CNT_W-1:0]   high_q,    high_d;
    logic [TIMES_W-1:0] pulses_q,  pulses_d;
    logic               valid_q,   valid_d;
    logic               timeout_q, timeout_d;

    logic timeout_hit;
    assign timeout_hit = (64'(p_cnt_q) >= TIMEOUT_X);

    always_comb begin
        state_d   = state_q;
        p_cnt_d   = p_cnt_q;
        h_lat_d   = h_lat_q;
        h_seen_d  = h_seen_q;
        period_d  = period_q;
        high_d    = high_q;
        pulses_d  = pulses_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;

        if (i_clr) begin
            state_d  = ST_IDLE;
            p_cnt_d  = '0;
            h_lat_d  = '0;
            h_seen_d = 1'b0;
            period_d = '0;
            high_d   = '0;
            pulses_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // First rise only arms; there is no complete period yet.
                    if (rise) begin
                        state_d  = ST_MEAS;
                        p_cnt_d  = CNT_W'(1);
                        h_lat_d  = '0;
                        h_seen_d = 1'b0;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        period_d = p_cnt_q;
                        high_d   = h_lat_q;
                        valid_d  = 1'b1;
                        pulses_d = (pulses_q == PULSE_MAX) ? pulses_q : pulses_q + 1'b1;
                        p_cnt_d  = CNT_W'(1);
                        h_lat_d  = '0;
                        h_seen_d = 1'b0;
                    end else if (timeout_hit) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        p_cnt_d   = '0;
                        h_lat_d   = '0;
                        h_seen_d  = 1'b0;
                    end else begin
                        p_cnt_d = (p_cnt_q == CNT_MAX) ? p_cnt_q : p_cnt_q + 1'b1;
                        if (fall && !h_seen_q) begin
                            h_lat_d  = p_cnt_q;
                            h_seen_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            p_cnt_q   <= '0;
            h_lat_q   <= '0;
            h_seen_q  <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            pulses_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_cnt_q   <= p_cnt_d;
            h_lat_q   <= h_lat_d;
            h_seen_q  <= h_seen_d;
            period_q  <= period_d;
            high_q    <= high_d;
            pulses_q  <= pulses_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_period  = period_q;
    assign o_high    = high_q;
    assign o_pulses  = pulses_q;
    assign o_valid   = valid_q;
    assign o_busy    = (state_q == ST_MEAS);
    assign o_timeout = timeout_q;

endmodule
